sdhci_card_cmd_responder: RTL

- Card-side end of the SD CMD line: the responder that answers the host controller's command engine.
- Deserialises 48-bit host commands, checks framing and CRC7, and hands index/argument to card-model logic.
- Serialises the 48-bit response after the NCR gap.
- Used as the card model in SDHCI integration benches and in FPGA loopback builds against the host command/status logic.

---
 rtl/sdhci_card_cmd_responder.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/sdhci_card_cmd_responder.sv
// sdhci_card_cmd_responder: card-side SD CMD line engine.
// Receives 48-bit host commands and checks the start, transmission and end
// bits plus the CRC7. It waits out the NCR gap, accepts one response from the
// card logic, then serialises that response and holds the line high for one
// NCC bit before releasing it.
// Optional build macro SDHCI_CARD_CRC_ERR_CNT_EN adds a saturating count of
// crc_err_o pulses and a clear input for it.
module sdhci_card_cmd_responder #(
  parameter int NCR_MIN = 2,
  parameter int NCR_MAX = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sd_clk_en_i,
  input  logic        cmd_i,
  output logic        cmd_o,
  output logic        cmd_oe_o,
  output logic        cmd_valid_o,
  output logic [5:0]  cmd_index_o,
  output logic [31:0] cmd_arg_o,
  output logic        crc_err_o,
  input  logic        rsp_valid_i,
  output logic        rsp_ready_o,
  input  logic        rsp_none_i,
  input  logic        rsp_no_crc_i,
  input  logic [5:0]  rsp_index_i,
  input  logic [31:0] rsp_arg_i,
  output logic        busy_o
`ifdef SDHCI_CARD_CRC_ERR_CNT_EN
  ,
  output logic [7:0]  crc_err_cnt_o,
  input  logic        crc_err_clr_i
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX,
    S_WAIT,
    S_TX,
    S_TAIL
  } state_t;

  localparam logic [6:0] NCR_RDY  = 7'(NCR_MIN - 1);
  localparam logic [6:0] NCR_LAST = 7'(NCR_MAX - 1);

  state_t      state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;   // frame bit index, shared by RX and TX
  logic [45:0] rx_sr_q, rx_sr_d;       // bits 1..46 of the incoming frame
  logic [6:0]  crc_q, crc_d;
  logic [6:0]  ncr_q, ncr_d;
  logic        taken_q, taken_d;       // response captured, waiting for TX strobe
  logic [47:0] tx_sr_q, tx_sr_d;       // outgoing frame, MSB on the line
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [5:0]  index_q, index_d;
  logic [31:0] arg_q, arg_d;
  logic        hs;

  // CRC7, polynomial x^7 + x^3 + 1, one bit per call
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:3], c[2] ^ fb, c[1:0], fb};
  endfunction

  // CRC7 over the 40 header/payload bits of an outgoing response
  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] c;
    c = 7'h00;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
    return c;
  endfunction

  assign rsp_ready_o = (state_q == S_WAIT) && !taken_q && (ncr_q >= NCR_RDY);
  assign hs          = rsp_valid_i && rsp_ready_o;
  assign cmd_oe_o    = (state_q == S_TX) || (state_q == S_TAIL);
  assign cmd_o       = (state_q == S_TX) ? tx_sr_q[47] : 1'b1;
  assign busy_o      = (state_q != S_IDLE);
  assign cmd_valid_o = valid_q;
  assign crc_err_o   = err_q;
  assign cmd_index_o = index_q;
  assign cmd_arg_o   = arg_q;

  // Next-state and datapath: line activity advances on strobes only, the
  // response handshake is taken in any clk_i cycle
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_sr_d   = rx_sr_q;
    crc_d     = crc_q;
    ncr_d     = ncr_q;
    taken_d   = taken_q;
    tx_sr_d   = tx_sr_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    index_d   = index_q;
    arg_d     = arg_q;
    case (state_q)
      S_IDLE: begin
        if (sd_clk_en_i && !cmd_i) begin
          state_d   = S_RX;
          bit_cnt_d = 6'd1;
          crc_d     = 7'h00;  // the start bit is 0 and leaves a cleared CRC unchanged
          rx_sr_d   = '0;
        end
      end
      S_RX: begin
        if (sd_clk_en_i) begin
          rx_sr_d   = {rx_sr_q[44:0], cmd_i};
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q <= 6'd39) crc_d = crc7_step(crc_q, cmd_i);
          if (bit_cnt_q == 6'd47) begin
            state_d = S_IDLE;
            // transmission bit 0 means another device's response: drop silently
            if (rx_sr_q[45]) begin
              if (rx_sr_q[6:0] == crc_q && cmd_i) begin
                valid_d = 1'b1;
                index_d = rx_sr_q[44:39];
                arg_d   = rx_sr_q[38:7];
                state_d = S_WAIT;
                ncr_d   = 7'd0;
                taken_d = 1'b0;
              end else begin
                err_d = 1'b1;
              end
            end
          end
        end
      end
      S_WAIT: begin
        if (hs) begin
          if (rsp_none_i) begin
            state_d = S_IDLE;
          end else begin
            taken_d = 1'b1;
            tx_sr_d = {2'b00, rsp_index_i, rsp_arg_i,
                       rsp_no_crc_i ? 7'h7F : crc7_40({2'b00, rsp_index_i, rsp_arg_i}),
                       1'b1};
          end
        end else if (sd_clk_en_i) begin
          if (taken_q) begin
            state_d   = S_TX;
            bit_cnt_d = 6'd0;
          end else if (ncr_q >= NCR_LAST) begin
            state_d = S_IDLE;
          end else begin
            ncr_d = ncr_q + 7'd1;
          end
        end
      end
      S_TX: begin
        if (sd_clk_en_i) begin
          if (bit_cnt_q == 6'd47) begin
            state_d = S_TAIL;
          end else begin
            tx_sr_d   = {tx_sr_q[46:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
      end
      S_TAIL: begin
        if (sd_clk_en_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any frame or pending response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      rx_sr_q   <= '0;
      crc_q     <= '0;
      ncr_q     <= '0;
      taken_q   <= 1'b0;
      tx_sr_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      index_q   <= '0;
      arg_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_sr_q   <= rx_sr_d;
      crc_q     <= crc_d;
      ncr_q     <= ncr_d;
      taken_q   <= taken_d;
      tx_sr_q   <= tx_sr_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      index_q   <= index_d;
      arg_q     <= arg_d;
    end
  end

`ifdef SDHCI_CARD_CRC_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  assign crc_err_cnt_o = err_cnt_q;

  // Saturating error count; clear has priority over a same-cycle increment
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (crc_err_clr_i)                      err_cnt_d = 8'd0;
    else if (err_q && err_cnt_q != 8'hFF)   err_cnt_d = err_cnt_q + 8'd1;
  end

  // Error count register
  always_ff @(posedge clk_i) begin
    if (rst_i) err_cnt_q <= 8'd0;
    else       err_cnt_q <= err_cnt_d;
  end
`endif

endmodule
